// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: access size / byte-strobe
// types and the arbiter state enum. Optional round-robin tie-break is
// selected with MEM_ARBITER_RR_EN (see arb_pick).
package mem_arbiter_pkg;

   typedef logic [2:0] msize_t;
   typedef logic [7:0] strobe_t;

   localparam int     XLEN       = 64;
   localparam msize_t SIZE_DWORD = 3'b011;  // instruction fetches are always 8 bytes

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      DONE_I,
      DONE_D
   } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant select between the fetch (ibus) and data (dbus)
// requesters. Default build: fixed dbus priority. With MEM_ARBITER_RR_EN
// defined, a 1-bit last-grant pointer breaks ties in favour of the requester
// that was not granted last; out of reset the pointer makes dbus win the
// first tie, so early behaviour matches the fixed-priority build.
module arb_pick
   import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
   input  logic clk,
   input  logic rst,
`endif
   input  logic idle,
   input  logic ireq_valid,
   input  logic dreq_valid,
   output logic grant_i,
   output logic grant_d
);

`ifdef MEM_ARBITER_RR_EN
   logic last_d_reg;  // 1 when dbus received the most recent grant

   // Track which requester won the most recent grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_d_reg <= 1'b0;
      end else if (grant_i || grant_d) begin
         last_d_reg <= grant_d;
      end
   end

   // On a tie, the requester that was not granted last wins.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (idle) begin
         if (dreq_valid && ireq_valid) begin
            grant_d = ~last_d_reg;
            grant_i = last_d_reg;
         end else begin
            grant_d = dreq_valid;
            grant_i = ireq_valid;
         end
      end
   end
`else
   // Fixed priority: dbus always wins a tie.
   always_comb begin
      grant_d = idle & dreq_valid;
      grant_i = idle & ireq_valid & ~dreq_valid;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / data) in front of a single-beat shared
// memory port. One transaction in flight at a time; request fields are
// captured at grant so requesters may change inputs while busy. Tie-break
// policy is chosen by MEM_ARBITER_RR_EN (undefined = fixed dbus priority).
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ireq_valid,
   input  logic [XLEN-1:0] ireq_addr,
   output logic            iresp_ok,
   output logic [XLEN-1:0] iresp_data,
   input  logic            dreq_valid,
   input  logic [XLEN-1:0] dreq_addr,
   input  msize_t          dreq_size,
   input  strobe_t         dreq_strobe,
   input  logic [XLEN-1:0] dreq_data,
   output logic            dresp_ok,
   output logic [XLEN-1:0] dresp_data,
   output logic            creq_valid,
   output logic [XLEN-1:0] creq_addr,
   output msize_t          creq_size,
   output strobe_t         creq_strobe,
   output logic [XLEN-1:0] creq_data,
   input  logic            cresp_ok,
   input  logic [XLEN-1:0] cresp_data
);

   arb_state_t      state_reg;
   logic [XLEN-1:0] addr_reg;
   msize_t          size_reg;
   strobe_t         strobe_reg;
   logic [XLEN-1:0] wdata_reg;
   logic [XLEN-1:0] rdata_reg;
   logic            creq_valid_reg;
   logic            iresp_ok_reg;
   logic            dresp_ok_reg;
   logic            grant_i;
   logic            grant_d;
   logic            idle;

   assign idle = (state_reg == IDLE);

   arb_pick u_pick (
`ifdef MEM_ARBITER_RR_EN
      .clk        (clk),
      .rst        (rst),
`endif
      .idle       (idle),
      .ireq_valid (ireq_valid),
      .dreq_valid (dreq_valid),
      .grant_i    (grant_i),
      .grant_d    (grant_d)
   );

   // Arbiter FSM: grant, capture request, wait for the port, pulse completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         size_reg       <= '0;
         strobe_reg     <= '0;
         wdata_reg      <= '0;
         rdata_reg      <= '0;
         creq_valid_reg <= 1'b0;
         iresp_ok_reg   <= 1'b0;
         dresp_ok_reg   <= 1'b0;
      end else begin
         iresp_ok_reg <= 1'b0;
         dresp_ok_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_d) begin
                  addr_reg       <= dreq_addr;
                  size_reg       <= dreq_size;
                  strobe_reg     <= dreq_strobe;
                  wdata_reg      <= dreq_data;
                  creq_valid_reg <= 1'b1;
                  state_reg      <= BUSY_D;
               end else if (grant_i) begin
                  addr_reg       <= ireq_addr;
                  size_reg       <= SIZE_DWORD;
                  strobe_reg     <= '0;
                  wdata_reg      <= '0;
                  creq_valid_reg <= 1'b1;
                  state_reg      <= BUSY_I;
               end
            end
            BUSY_I, BUSY_D: begin
               // Without a response everything holds, so creq_* stays stable.
               if (cresp_ok) begin
                  rdata_reg      <= cresp_data;
                  creq_valid_reg <= 1'b0;
                  if (state_reg == BUSY_I) begin
                     iresp_ok_reg <= 1'b1;
                     state_reg    <= DONE_I;
                  end else begin
                     dresp_ok_reg <= 1'b1;
                     state_reg    <= DONE_D;
                  end
               end
            end
            // Always return through IDLE so a requester dropping valid right
            // after its pulse is never granted a second time.
            DONE_I, DONE_D: state_reg <= IDLE;
            default:        state_reg <= IDLE;
         endcase
      end
   end

   assign creq_valid  = creq_valid_reg;
   assign creq_addr   = addr_reg;
   assign creq_size   = size_reg;
   assign creq_strobe = strobe_reg;
   assign creq_data   = wdata_reg;
   assign iresp_ok    = iresp_ok_reg;
   assign dresp_ok    = dresp_ok_reg;
   assign iresp_data  = iresp_ok_reg ? rdata_reg : '0;
   assign dresp_data  = dresp_ok_reg ? rdata_reg : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences (priority, stability, reset mid-transaction, repeated
// ties) and randomized transactions against a transaction-level model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            ireq_valid;
   logic [63:0]     ireq_addr;
   logic            iresp_ok;
   logic [63:0]     iresp_data;
   logic            dreq_valid;
   logic [63:0]     dreq_addr;
   logic [2:0]      dreq_size;
   logic [7:0]      dreq_strobe;
   logic [63:0]     dreq_data;
   logic            dresp_ok;
   logic [63:0]     dresp_data;
   logic            creq_valid;
   logic [63:0]     creq_addr;
   logic [2:0]      creq_size;
   logic [7:0]      creq_strobe;
   logic [63:0]     creq_data;
   logic            cresp_ok;
   logic [63:0]     cresp_data;

   int n_tests = 0;
   int n_fail  = 0;
   bit tb_last_d = 1'b0;   // model: dbus was granted most recently

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_ok(iresp_ok), .iresp_data(iresp_data),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_ok(dresp_ok), .dresp_data(dresp_data),
      .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_size(creq_size),
      .creq_strobe(creq_strobe), .creq_data(creq_data),
      .cresp_ok(cresp_ok), .cresp_data(cresp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          dv;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strb;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          lat;
      logic [63:0] e_addr;
      logic [2:0]  e_size;
      logic [7:0]  e_strb;
      logic [63:0] e_data;
   } vec_t;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Winner for a set of pending requesters, from the arbitration rules.
   function automatic bit model_pick_d(input bit iv, input bit dv);
      if (dv && !iv) return 1'b1;
      if (iv && !dv) return 1'b0;
`ifdef MEM_ARBITER_RR_EN
      return !tb_last_d;
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_iok"},   64'(iresp_ok),   64'd0);
      chk({tag, "_dok"},   64'(dresp_ok),   64'd0);
      chk({tag, "_idata"}, iresp_data,      64'd0);
      chk({tag, "_ddata"}, dresp_data,      64'd0);
      chk({tag, "_cval"},  64'(creq_valid), 64'd0);
   endtask

   // Called at the negedge right after the grant edge. Plays the memory,
   // checks the port request every busy cycle and the completion pulse.
   task automatic serve(input bit is_d, input logic [63:0] e_addr, input logic [2:0] e_size,
                        input logic [7:0] e_strb, input logic [63:0] e_data, input int lat,
                        input logic [63:0] rdata, input bit mutate, input bit keep);
      for (int k = 0; k <= lat; k++) begin
         chk("creq_valid", 64'(creq_valid), 64'd1);
         chk("creq_addr",  creq_addr,        e_addr);
         chk("creq_size",  64'(creq_size),   64'(e_size));
         chk("creq_strobe",64'(creq_strobe), 64'(e_strb));
         chk("creq_data",  creq_data,        e_data);
         chk("busy_iok",   64'(iresp_ok),    64'd0);
         chk("busy_dok",   64'(dresp_ok),    64'd0);
         if (k < lat) begin
            cresp_ok   = 1'b0;
            cresp_data = {$urandom, $urandom};
            if (mutate) begin
               if (is_d) begin
                  dreq_addr   = {$urandom, $urandom};
                  dreq_data   = {$urandom, $urandom};
                  dreq_strobe = 8'($urandom);
                  dreq_size   = 3'($urandom);
                  dreq_valid  = 1'($urandom_range(0, 1));
               end else begin
                  ireq_addr  = {$urandom, $urandom};
                  ireq_valid = 1'($urandom_range(0, 1));
               end
            end
         end else begin
            cresp_ok   = 1'b1;
            cresp_data = rdata;
         end
         step();
      end
      cresp_ok   = 1'b0;
      cresp_data = {$urandom, $urandom};
      if (is_d) begin
         chk("dresp_ok",   64'(dresp_ok), 64'd1);
         chk("dresp_data", dresp_data,    rdata);
         chk("done_iok",   64'(iresp_ok), 64'd0);
         chk("done_idata", iresp_data,    64'd0);
      end else begin
         chk("iresp_ok",   64'(iresp_ok), 64'd1);
         chk("iresp_data", iresp_data,    rdata);
         chk("done_dok",   64'(dresp_ok), 64'd0);
         chk("done_ddata", dresp_data,    64'd0);
      end
      chk("done_cval", 64'(creq_valid), 64'd0);
      $display("[TB] txn %s addr=%h rdata=%h lat=%0d", is_d ? "D" : "I", e_addr, rdata, lat);
      if (!keep) begin
         if (is_d) dreq_valid = 1'b0;
         else      ireq_valid = 1'b0;
      end
      step();
      chk_quiet("idle");
   endtask

   vec_t vecs[5];
   bit   order_exp[4];
   bit   w;

   initial begin
      rst = 1'b1; ireq_valid = 0; ireq_addr = 0; dreq_valid = 0; dreq_addr = 0;
      dreq_size = 0; dreq_strobe = 0; dreq_data = 0; cresp_ok = 0; cresp_data = 0;

      vecs[0] = '{1'b1, 64'h0000_0000_8000_0010, 3'd3, 8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF, 1,
                  64'h0000_0000_8000_0010, 3'd3, 8'h00, 64'h0};
      vecs[1] = '{1'b1, 64'h0000_0000_0000_1000, 3'd3, 8'hF0, 64'h1122_3344_5566_7788, 64'h0, 0,
                  64'h0000_0000_0000_1000, 3'd3, 8'hF0, 64'h1122_3344_5566_7788};
      vecs[2] = '{1'b0, 64'h0000_0000_4000_0000, 3'd7, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA,
                  64'h0123_4567_89AB_CDEF, 2, 64'h0000_0000_4000_0000, 3'd3, 8'h00, 64'h0};
      vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 3'd0, 8'h01, 64'h0000_0000_0000_00FF,
                  64'hFFFF_FFFF_FFFF_FFFF, 3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd0, 8'h01, 64'h0000_0000_0000_00FF};
      vecs[4] = '{1'b0, 64'h0, 3'd1, 8'h3C, 64'h5555, 64'h0, 0, 64'h0, 3'd3, 8'h00, 64'h0};

      // Reset state
      repeat (3) step();
      chk_quiet("rst");
      chk("rst_addr",  creq_addr,         64'd0);
      chk("rst_size",  64'(creq_size),    64'd0);
      chk("rst_strb",  64'(creq_strobe),  64'd0);
      chk("rst_wdata", creq_data,         64'd0);
      rst = 1'b0;
      step();
      chk_quiet("post_rst");

      // Directed single-requester vectors
      foreach (vecs[v]) begin
         ireq_addr   = vecs[v].addr;
         dreq_addr   = vecs[v].addr;
         dreq_size   = vecs[v].size;
         dreq_strobe = vecs[v].strb;
         dreq_data   = vecs[v].wdata;
         dreq_valid  = vecs[v].dv;
         ireq_valid  = !vecs[v].dv;
         tb_last_d   = vecs[v].dv;
         step();
         serve(vecs[v].dv, vecs[v].e_addr, vecs[v].e_size, vecs[v].e_strb, vecs[v].e_data,
               vecs[v].lat, vecs[v].rdata, 1'b0, 1'b0);
      end

      // Both requesters at once: served in model order, each with its own address
      ireq_addr = 64'h0000_0000_0000_2000; dreq_addr = 64'h0000_0000_0000_3000;
      dreq_size = 3'd2; dreq_strobe = 8'h0F; dreq_data = 64'h0000_0000_CAFE_F00D;
      ireq_valid = 1'b1; dreq_valid = 1'b1;
      w = model_pick_d(1'b1, 1'b1);
      tb_last_d = w;
      step();
      if (w) serve(1'b1, 64'h3000, 3'd2, 8'h0F, 64'hCAFE_F00D, 1, 64'h11, 1'b0, 1'b0);
      else   serve(1'b0, 64'h2000, 3'd3, 8'h00, 64'h0,         1, 64'h22, 1'b0, 1'b0);
      tb_last_d = !w;
      step();
      if (w) serve(1'b0, 64'h2000, 3'd3, 8'h00, 64'h0,         0, 64'h22, 1'b0, 1'b0);
      else   serve(1'b1, 64'h3000, 3'd2, 8'h0F, 64'hCAFE_F00D, 0, 64'h11, 1'b0, 1'b0);

      // Inputs change while the port withholds its response for 5 cycles
      dreq_addr = 64'h0000_0000_0000_5550; dreq_size = 3'd3; dreq_strobe = 8'hFF;
      dreq_data = 64'h0BAD_0BAD_0BAD_0BAD; dreq_valid = 1'b1; ireq_valid = 1'b0;
      tb_last_d = 1'b1;
      step();
      serve(1'b1, 64'h5550, 3'd3, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, 5, 64'h77, 1'b1, 1'b0);
      dreq_valid = 1'b0;

      // Reset in the middle of a fetch, then a late port response
      ireq_addr = 64'h0000_0000_0000_9000; ireq_valid = 1'b1;
      step();
      chk("rb_cval", 64'(creq_valid), 64'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; cresp_ok = 1'b1; cresp_data = 64'h1234; ireq_valid = 1'b0;
      tb_last_d = 1'b0;
      chk("rb_cval_rst", 64'(creq_valid), 64'd0);
      chk("rb_addr_rst", creq_addr,       64'd0);
      step();
      cresp_ok = 1'b0;
      chk_quiet("rb_late");
      step();
      chk_quiet("rb_after");

      // Four transactions with both requesters continuously pending
`ifdef MEM_ARBITER_RR_EN
      order_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      order_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = 64'h0;
      ireq_valid = 1'b1; dreq_valid = 1'b1;
      for (int t = 0; t < 4; t++) begin
         dreq_addr = 64'hD000 + 64'(t);
         ireq_addr = 64'h1000 + 64'(t);
         w = model_pick_d(1'b1, 1'b1);
         tb_last_d = w;
         step();
         chk("grant_order", 64'(creq_addr == 64'hD000 + 64'(t)), 64'(order_exp[t]));
         if (w) serve(1'b1, 64'hD000 + 64'(t), 3'd3, 8'h00, 64'h0, t, 64'(t), 1'b0, 1'b1);
         else   serve(1'b0, 64'h1000 + 64'(t), 3'd3, 8'h00, 64'h0, t, 64'(t), 1'b0, 1'b1);
      end
      ireq_valid = 1'b0; dreq_valid = 1'b0;
      step();
      chk_quiet("cont_end");

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         bit          iv, dv, mut, first;
         logic [63:0] ia, da, dd, r1, r2;
         logic [2:0]  ds;
         logic [7:0]  st;
         iv = 1'($urandom_range(0, 1));
         dv = 1'($urandom_range(0, 1));
         if (!iv && !dv) begin
            cresp_ok = 1'($urandom_range(0, 1)); cresp_data = {$urandom, $urandom};
            step();
            cresp_ok = 1'b0;
            chk_quiet("rnd_idle");
            continue;
         end
         ia = {$urandom, $urandom}; da = {$urandom, $urandom}; dd = {$urandom, $urandom};
         ds = 3'($urandom); st = 8'($urandom);
         r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
         mut = 1'($urandom_range(0, 1));
         ireq_addr = ia; dreq_addr = da; dreq_data = dd; dreq_size = ds; dreq_strobe = st;
         ireq_valid = iv; dreq_valid = dv;
         first = model_pick_d(iv, dv);
         tb_last_d = first;
         step();
         if (first) serve(1'b1, da, ds, st, dd, $urandom_range(0, 4), r1, mut, 1'b0);
         else       serve(1'b0, ia, 3'd3, 8'h00, 64'h0, $urandom_range(0, 4), r1, mut, 1'b0);
         if (iv && dv) begin
            tb_last_d = !first;
            step();
            if (first) serve(1'b0, ia, 3'd3, 8'h00, 64'h0, $urandom_range(0, 4), r2, 1'b0, 1'b0);
            else       serve(1'b1, da, ds, st, dd, $urandom_range(0, 4), r2, 1'b0, 1'b0);
         end
         ireq_valid = 1'b0; dreq_valid = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
